// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared IEEE-754 single-precision field constants, state enum
//               and classification helpers for the fp_multiplier/accumulator.
// Revision    : 1.0
// ============================================================================
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int BIAS     = 127;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;
  localparam logic [31:0] NEG_INF = 32'hff800000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPECIAL = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_ADD     = 3'd3,
    ST_NORM    = 3'd4,
    ST_WRITE   = 3'd5
  } state_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[EXP_HI:EXP_LO] == 8'hff) && (w[MAN_HI:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] w);
    return (w[EXP_HI:EXP_LO] == 8'hff) && (w[MAN_HI:0] == '0);
  endfunction

  // Denormals are flushed, so a zero exponent alone classifies as zero.
  function automatic logic is_zero(input logic [31:0] w);
    return (w[EXP_HI:EXP_LO] == 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp_unpack
// Description : Splits a single-precision word into sign, exponent, 24-bit
//               mantissa (hidden bit restored) and class flags.
// Revision    : 1.0
// ============================================================================
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_word,
  output logic                 o_sign,
  output logic [EXP_W-1:0]     o_exp,
  output logic [MAN_W:0]       o_man,
  output logic                 o_nan,
  output logic                 o_inf,
  output logic                 o_zero
);

  assign o_sign = i_word[SIGN_BIT];
  assign o_exp  = i_word[EXP_HI:EXP_LO];
  assign o_man  = {1'b1, i_word[MAN_HI:0]};
  assign o_nan  = is_nan(i_word);
  assign o_inf  = is_inf(i_word);
  assign o_zero = is_zero(i_word);

endmodule
`default_nettype wire

// File: rtl/fp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp_accumulator
// Description : Multi-cycle single-precision accumulator (align, add,
//               normalise one bit per cycle) with valid/ready input.
// Revision    : 1.0
// ============================================================================
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 int_clk,
  input  logic                 reset,
  input  logic [EXP_W+MAN_W:0] In,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  input  logic                 last,
  output logic [EXP_W+MAN_W:0] Out,
  output logic                 out_valid
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1;

  state_t r_state, w_next;

  logic [W-1:0]     r_op, r_out, r_res;
  logic             r_clr, r_last;
  logic             r_sa, r_sb, r_sign;
  logic [EXP_W-1:0] r_ea, r_d, r_exp;
  logic [MW-1:0]    r_ma, r_mb;
  logic [MW:0]      r_sum;

  logic [W-1:0]     w_x_word;
  logic             w_x_sign, w_x_nan, w_x_inf, w_x_zero;
  logic             w_y_sign, w_y_nan, w_y_inf, w_y_zero;
  logic [EXP_W-1:0] w_x_exp, w_y_exp;
  logic [MW-1:0]    w_x_man, w_y_man;

  assign w_x_word = r_clr ? '0 : r_out;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_x (
    .i_word(w_x_word), .o_sign(w_x_sign), .o_exp(w_x_exp), .o_man(w_x_man),
    .o_nan(w_x_nan), .o_inf(w_x_inf), .o_zero(w_x_zero)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_y (
    .i_word(r_op), .o_sign(w_y_sign), .o_exp(w_y_exp), .o_man(w_y_man),
    .o_nan(w_y_nan), .o_inf(w_y_inf), .o_zero(w_y_zero)
  );

  // Special-value resolution and operand ordering
  logic             w_spec_hit, w_swap, w_skip;
  logic [W-1:0]     w_spec_res, w_big_word;
  logic [EXP_W-1:0] w_d;

  always_comb begin
    w_spec_hit = 1'b0;
    w_spec_res = '0;
    if (w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_x_sign != w_y_sign))) begin
      w_spec_hit = 1'b1;
      w_spec_res = QNAN;
    end else if (w_x_inf) begin
      w_spec_hit = 1'b1;
      w_spec_res = w_x_word;
    end else if (w_y_inf) begin
      w_spec_hit = 1'b1;
      w_spec_res = r_op;
    end else if (w_y_zero) begin
      w_spec_hit = 1'b1;
      w_spec_res = w_x_word;
    end else if (w_x_zero) begin
      w_spec_hit = 1'b1;
      w_spec_res = r_op;
    end
  end

  assign w_swap     = (w_y_exp > w_x_exp);
  assign w_d        = w_swap ? (w_y_exp - w_x_exp) : (w_x_exp - w_y_exp);
  assign w_skip     = (w_d > EXP_W'(MW));
  assign w_big_word = w_swap ? r_op : w_x_word;

  // Add/subtract of aligned magnitudes
  logic          w_same, w_a_ge, w_cancel, w_sum_sign;
  logic [MW:0]   w_sum;

  assign w_same     = (r_sa == r_sb);
  assign w_a_ge     = (r_ma >= r_mb);
  assign w_cancel   = !w_same && (r_ma == r_mb);
  assign w_sum      = w_same ? ({1'b0, r_ma} + {1'b0, r_mb})
                    : (w_a_ge ? ({1'b0, r_ma} - {1'b0, r_mb})
                              : ({1'b0, r_mb} - {1'b0, r_ma}));
  assign w_sum_sign = (w_same || w_a_ge) ? r_sa : r_sb;

  // One normalisation step
  logic             w_n_ovf, w_n_unf, w_n_done;
  logic [MW:0]      w_n_sum;
  logic [EXP_W-1:0] w_n_exp;

  always_comb begin
    w_n_ovf = 1'b0;
    w_n_unf = 1'b0;
    if (r_sum[MW]) begin
      w_n_sum = r_sum >> 1;
      w_n_exp = r_exp + 1'b1;
      w_n_ovf = (w_n_exp == '1);
    end else begin
      w_n_sum = r_sum << 1;
      w_n_exp = r_exp - 1'b1;
      w_n_unf = (w_n_exp == '0);
    end
    w_n_done = w_n_sum[MW-1] || w_n_ovf || w_n_unf;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        if (w_spec_hit || w_skip) w_next = ST_WRITE;
        else if (w_d == '0)       w_next = ST_ADD;
        else                      w_next = ST_ALIGN;
      end
      ST_ALIGN: if (r_d == EXP_W'(1)) w_next = ST_ADD;
      ST_ADD: begin
        if (w_cancel || (!w_sum[MW] && w_sum[MW-1])) w_next = ST_WRITE;
        else                                        w_next = ST_NORM;
      end
      ST_NORM: if (w_n_done) w_next = ST_WRITE;
      ST_WRITE: begin
        out_valid = r_last;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) begin
      r_op   <= '0;  r_out <= '0;  r_res <= '0;
      r_clr  <= 1'b0; r_last <= 1'b0;
      r_sa   <= 1'b0; r_sb <= 1'b0; r_sign <= 1'b0;
      r_ea   <= '0;  r_d <= '0;   r_exp <= '0;
      r_ma   <= '0;  r_mb <= '0;  r_sum <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op   <= In;
          r_clr  <= clear;
          r_last <= last;
        end
        ST_SPECIAL: begin
          r_res <= w_spec_hit ? w_spec_res : w_big_word;
          r_sa  <= w_swap ? w_y_sign : w_x_sign;
          r_ea  <= w_swap ? w_y_exp  : w_x_exp;
          r_ma  <= w_swap ? w_y_man  : w_x_man;
          r_sb  <= w_swap ? w_x_sign : w_y_sign;
          r_mb  <= w_swap ? w_x_man  : w_y_man;
          r_d   <= w_d;
        end
        ST_ALIGN: begin
          r_mb <= r_mb >> 1;
          r_d  <= r_d - 1'b1;
        end
        ST_ADD: begin
          r_sum  <= w_sum;
          r_sign <= w_sum_sign;
          r_exp  <= r_ea;
          r_res  <= w_cancel ? '0 : {w_sum_sign, r_ea, w_sum[MAN_W-1:0]};
        end
        ST_NORM: begin
          r_sum <= w_n_sum;
          r_exp <= w_n_exp;
          if (w_n_ovf)      r_res <= r_sign ? NEG_INF : POS_INF;
          else if (w_n_unf) r_res <= '0;
          else              r_res <= {r_sign, w_n_exp, w_n_sum[MAN_W-1:0]};
        end
        ST_WRITE: r_out <= r_res;
        default: ;
      endcase
    end
  end

  assign Out = r_out;

endmodule
`default_nettype wire
